// File: rtl/sram_req_responder_if.sv
// Client-side handshake into the SRAM responder: one read port and one write port.
// The master is the SRAM client (e.g. register access); the slave is the responder.
interface sram_req_responder_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 36
) ();

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic [DATA_W-1:0] rd_data;
  logic              rd_vld;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data,
    input  rd_ack, rd_data, rd_vld, wr_ack
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
    output rd_ack, rd_data, rd_vld, wr_ack
  );

endinterface

// File: rtl/sram_req_responder.sv
// Arbitrates one client's read and write ports onto a ZBT pipelined SRAM.
// Write data reaches the bus two cycles after its command; read data returns three cycles after rd_ack.
module sram_req_responder #(
  parameter int SRAM_ADDR_WIDTH = 19,
  parameter int SRAM_DATA_WIDTH = 36,
  parameter int SRAM_BW_WIDTH   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  sram_req_responder_if.slave        cli,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic                       sram_we_n,
  output logic [SRAM_BW_WIDTH-1:0]   sram_bw_n,
  output logic [SRAM_DATA_WIDTH-1:0] sram_wr_data,
  output logic                       sram_tri_en,
  input  logic [SRAM_DATA_WIDTH-1:0] sram_rd_data
);

  // state   | meaning
  // LAST_RD | read won the most recent grant; a tie goes to write
  // LAST_WR | write won the most recent grant (reset); a tie goes to read
  typedef enum logic {
    LAST_RD = 1'b0,
    LAST_WR = 1'b1
  } last_t;

  last_t                      last_q, last_d;
  logic                       rd_ack_q, rd_ack_d;
  logic                       wr_ack_q, wr_ack_d;
  logic                       rd_vld_q, rd_vld_d;
  logic [SRAM_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [SRAM_ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
  logic                       sram_we_n_q, sram_we_n_d;
  logic [SRAM_BW_WIDTH-1:0]   sram_bw_n_q, sram_bw_n_d;
  logic [SRAM_DATA_WIDTH-1:0] sram_wr_data_q, sram_wr_data_d;
  logic                       sram_tri_en_q, sram_tri_en_d;
  logic [2:0]                 rd_tag_q, rd_tag_d;
  logic [1:0]                 wr_vld_q, wr_vld_d;
  logic [SRAM_DATA_WIDTH-1:0] wr_pipe0_q, wr_pipe0_d;
  logic [SRAM_DATA_WIDTH-1:0] wr_pipe1_q, wr_pipe1_d;

  logic rd_elig, wr_elig, grant_rd, grant_wr;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q         <= LAST_WR;
      rd_ack_q       <= 1'b0;
      wr_ack_q       <= 1'b0;
      rd_vld_q       <= 1'b0;
      rd_data_q      <= '0;
      sram_addr_q    <= '0;
      sram_we_n_q    <= 1'b1;
      sram_bw_n_q    <= '1;
      sram_wr_data_q <= '0;
      sram_tri_en_q  <= 1'b0;
      rd_tag_q       <= '0;
      wr_vld_q       <= '0;
      wr_pipe0_q     <= '0;
      wr_pipe1_q     <= '0;
    end else begin
      last_q         <= last_d;
      rd_ack_q       <= rd_ack_d;
      wr_ack_q       <= wr_ack_d;
      rd_vld_q       <= rd_vld_d;
      rd_data_q      <= rd_data_d;
      sram_addr_q    <= sram_addr_d;
      sram_we_n_q    <= sram_we_n_d;
      sram_bw_n_q    <= sram_bw_n_d;
      sram_wr_data_q <= sram_wr_data_d;
      sram_tri_en_q  <= sram_tri_en_d;
      rd_tag_q       <= rd_tag_d;
      wr_vld_q       <= wr_vld_d;
      wr_pipe0_q     <= wr_pipe0_d;
      wr_pipe1_q     <= wr_pipe1_d;
    end
  end

  always_comb begin
    last_d         = last_q;
    rd_ack_d       = 1'b0;
    wr_ack_d       = 1'b0;
    sram_addr_d    = sram_addr_q;
    sram_we_n_d    = 1'b1;
    sram_bw_n_d    = '1;
    wr_pipe0_d     = wr_pipe0_q;
    wr_pipe1_d     = wr_pipe1_q;
    sram_wr_data_d = sram_wr_data_q;
    rd_data_d      = rd_data_q;

    // The client's req is still high the cycle after its ack, so block that cycle.
    rd_elig  = cli.rd_req && !rd_ack_q;
    wr_elig  = cli.wr_req && !wr_ack_q;
    grant_rd = rd_elig && (!wr_elig || (last_q == LAST_WR));
    grant_wr = wr_elig && !grant_rd;

    if (grant_rd) begin
      last_d      = LAST_RD;
      rd_ack_d    = 1'b1;
      sram_addr_d = cli.rd_addr;
    end else if (grant_wr) begin
      last_d      = LAST_WR;
      wr_ack_d    = 1'b1;
      sram_addr_d = cli.wr_addr;
      sram_we_n_d = 1'b0;
      sram_bw_n_d = '0;
      wr_pipe0_d  = cli.wr_data;
    end

    // Write data lands on the bus in the second cycle after its command.
    wr_vld_d = {wr_vld_q[0], grant_wr};
    if (wr_vld_q[0]) begin
      wr_pipe1_d = wr_pipe0_q;
    end
    sram_tri_en_d = wr_vld_q[1];
    if (wr_vld_q[1]) begin
      sram_wr_data_d = wr_pipe1_q;
    end

    // Read data is on the bus in the second cycle after its command; capture it then.
    rd_tag_d = {rd_tag_q[1:0], grant_rd};
    rd_vld_d = rd_tag_q[2];
    if (rd_tag_q[2]) begin
      rd_data_d = sram_rd_data;
    end
  end

  assign cli.rd_ack   = rd_ack_q;
  assign cli.wr_ack   = wr_ack_q;
  assign cli.rd_vld   = rd_vld_q;
  assign cli.rd_data  = rd_data_q;
  assign sram_addr    = sram_addr_q;
  assign sram_we_n    = sram_we_n_q;
  assign sram_bw_n    = sram_bw_n_q;
  assign sram_wr_data = sram_wr_data_q;
  assign sram_tri_en  = sram_tri_en_q;

endmodule

// File: doc/sram_req_responder.md
Name: sram_req_responder

Overview:
- Responder side of the SRAM requester handshake (rd_req/rd_ack/rd_vld, wr_req/wr_ack) used by register-access and other SRAM clients.
- Accepts one read port and one write port from a single client, arbitrates between them and drives a ZBT-style pipelined synchronous SRAM.
- Returns read data with a fixed latency.
- Sits between a client (e.g. register-access) and the external SRAM pins.

Parameters:
- SRAM_ADDR_WIDTH, 19, word address width.
- SRAM_DATA_WIDTH, 36, data word width.
- SRAM_BW_WIDTH, 4, byte-write enable width; all lanes are written on every write.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- rd_req  in  1  read request; held until rd_ack.
- rd_addr  in  SRAM_ADDR_WIDTH  read address; valid while rd_req is high.
- rd_ack  out  1  one-cycle pulse: read accepted.
- rd_data  out  SRAM_DATA_WIDTH  read data; valid when rd_vld is high.
- rd_vld  out  1  one-cycle pulse: rd_data valid.
- wr_req  in  1  write request; held until wr_ack.
- wr_addr  in  SRAM_ADDR_WIDTH  write address.
- wr_data  in  SRAM_DATA_WIDTH  write data; sampled at acceptance.
- wr_ack  out  1  one-cycle pulse: write accepted.
- sram_addr  out  SRAM_ADDR_WIDTH  SRAM address.
- sram_we_n  out  1  SRAM write enable, active-low.
- sram_bw_n  out  SRAM_BW_WIDTH  byte-write enables, active-low.
- sram_wr_data  out  SRAM_DATA_WIDTH  data driven onto the SRAM bus.
- sram_tri_en  out  1  1 = drive the SRAM data bus.
- sram_rd_data  in  SRAM_DATA_WIDTH  data sampled from the SRAM bus.

Behaviour:
- All outputs are registered.
- Reset values:
  - rd_ack, wr_ack, rd_vld, sram_tri_en = 0.
  - sram_we_n = 1, sram_bw_n = all 1s.
  - sram_addr, sram_wr_data, rd_data = 0.
  - Pipeline and history state cleared; last_served = write (so the first conflict grants read).
- Acceptance (at most one per cycle), at edge T:
  - Read eligible: rd_req=1 and rd_ack was not asserted in the preceding cycle. This is a block window: the client's req is registered and is still high the cycle after ack, so it must not be re-accepted.
  - Write eligible: same rule using wr_req and wr_ack.
  - Only one eligible: grant it.
  - Both eligible: grant the port opposite last_served, then update last_served.
- Read granted at T:
  - rd_ack=1 for the cycle after T.
  - sram_addr=rd_addr, sram_we_n=1.
  - Read tag enters a 3-stage shift register.
- Write granted at T:
  - wr_ack=1 for the cycle after T.
  - sram_addr=wr_addr, sram_we_n=0, sram_bw_n=0.
  - wr_data is latched into a 2-stage data pipe.
- Idle cycle: sram_we_n=1, sram_bw_n all 1s; sram_addr holds its last value.
- ZBT timing, with command presented in cycle C (output registers updated at edge T, C = T+1):
  - Write: sram_wr_data = latched data and sram_tri_en=1 in cycle C+2 only.
  - Read: SRAM data is valid in cycle C+2 and captured at the end of C+2. rd_data and rd_vld=1 appear in cycle C+3.
  - Read latency from ack cycle to rd_vld cycle = 3 cycles.
- Back-to-back operations: both ports alternating every cycle is legal; there are no bus turnaround bubbles (ZBT). Each port can be accepted at most every other cycle because of the block window.
- Read-after-write to the same address: no forwarding needed; the SRAM pipeline handles it. The read returns the new data when the read command follows the write command.
- rd_vld never coincides with a tri-state conflict: pipeline depths guarantee tri_en and read capture fall in different cycles for any ordering.
- Reset mid-operation: in-flight reads are discarded (no rd_vld), pending write data is dropped, and sram_tri_en returns to 0 in the cycle after reset.
- Requests that drop before ack are ignored; no error is raised.

Test Plan:
- Single read: rd_req=1, rd_addr=0x00010, SRAM model word 0x9_ABCD_1234 → rd_ack in cycle 1, rd_vld with rd_data=0x9ABCD1234 in cycle 4; req held through ack is not re-accepted.
- Single write then read: wr_req with addr 0x7FFFF, data 0xF_0000_0001 → wr_ack pulse, sram_we_n=0 for one cycle, sram_tri_en=1 two cycles later. Subsequent read returns 0xF00000001.
- Simultaneous rd_req and wr_req from reset → read granted first, write on the next eligible cycle. With both held continuously, grants alternate R,W,R,W and no port is acked in consecutive cycles.
- Streamed reads of addresses 0,1,2,3 (req re-asserted after each ack) → rd_vld order 0,1,2,3 with matching data, each 3 cycles after its ack.
- Reset asserted one cycle after a read ack → no rd_vld, all outputs at reset values; a new read after reset completes normally.
- Read-modify-write sequence as issued by the register-access client (read, then write to the same address) → final SRAM contents equal the written word, and exactly one rd_ack, one rd_vld and one wr_ack are seen.
